// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed 7-segment scanner with blanking gaps between digit slots
// and a frame-synchronous display register that is only refreshed between frames.
module seg7_scan_ctrl #(
   parameter int unsigned REFRESH_DIV  = 16000,
   parameter int unsigned BLANK_CYCLES = 160
) (
   input  logic       clk_16mhz,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic       load,
   input  logic [1:0] digit_en,
   input  logic [1:0] dp_in,
   output logic [6:0] seg,
   output logic       seg_dp,
   output logic       digit_sel,
   output logic       frame_done
);

   localparam int unsigned MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      SHOW0  = 2'd1,
      BLANK1 = 2'd2,
      SHOW1  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       pend_q, pend_d;
   logic [7:0]       disp_q, disp_d;
   logic             slot_last;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      pend_d    = pend_q;
      disp_d    = disp_q;
      slot_last = 1'b0;

      if (state_q == SHOW0 || state_q == SHOW1) begin
         slot_last = (cnt_q == CNT_W'(REFRESH_DIV - 1));
      end else begin
         slot_last = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
      end

      if (slot_last) begin
         cnt_d = '0;
         case (state_q)
            BLANK0:  state_d = SHOW0;
            SHOW0:   state_d = BLANK1;
            BLANK1:  state_d = SHOW1;
            default: state_d = BLANK0;
         endcase
      end

      if (load) begin
         pend_d = value;
      end

      // A load landing on the frame boundary bypasses pending so it is not lost a frame.
      if (state_q == SHOW1 && slot_last) begin
         disp_d = load ? value : pend_q;
      end
   end

   always_ff @(posedge clk_16mhz) begin
      if (rst) begin
         state_q <= BLANK0;
         cnt_q   <= '0;
         pend_q  <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
      end
   end

   always_comb begin
      seg        = '0;
      seg_dp     = 1'b0;
      digit_sel  = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         SHOW0: begin
            if (digit_en[0]) begin
               seg    = hex7(disp_q[3:0]);
               seg_dp = dp_in[0];
            end
         end
         BLANK1: begin
            digit_sel = 1'b1;
         end
         SHOW1: begin
            digit_sel  = 1'b1;
            frame_done = (cnt_q == CNT_W'(REFRESH_DIV - 1));
            if (digit_en[1]) begin
               seg    = hex7(disp_q[7:4]);
               seg_dp = dp_in[1];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2 (20-cycle frame).
module tb_seg7_scan_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] value;
   logic       load;
   logic [1:0] digit_en;
   logic [1:0] dp_in;
   logic [6:0] seg;
   logic       seg_dp;
   logic       digit_sel;
   logic       frame_done;

   int checks = 0;
   int errors = 0;
   int cur    = 0;

   logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      int         cyc;
      logic       ld;
      logic [7:0] val;
      logic [1:0] en;
      logic [1:0] dp;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_sel;
      logic       e_fd;
   } vec_t;

   vec_t vecs[$];

   seg7_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk_16mhz (clk),
      .rst       (rst),
      .value     (value),
      .load      (load),
      .digit_en  (digit_en),
      .dp_in     (dp_in),
      .seg       (seg),
      .seg_dp    (seg_dp),
      .digit_sel (digit_sel),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(int c, logic ld, logic [7:0] val, logic [1:0] en, logic [1:0] dp,
                               logic [6:0] s, logic d, logic sel, logic fd);
      vec_t r;
      r.cyc = c; r.ld = ld; r.val = val; r.en = en; r.dp = dp;
      r.e_seg = s; r.e_dp = d; r.e_sel = sel; r.e_fd = fd;
      return r;
   endfunction

   task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %h required %h", nm, c, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [6:0] s, input logic d, input logic sel,
                          input logic fd);
      chk({nm, ".seg"}, cur, {1'b0, seg}, {1'b0, s});
      chk({nm, ".dp"}, cur, {7'b0, seg_dp}, {7'b0, d});
      chk({nm, ".sel"}, cur, {7'b0, digit_sel}, {7'b0, sel});
      chk({nm, ".fd"}, cur, {7'b0, frame_done}, {7'b0, fd});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic run_to(input int t);
      while (cur < t) begin
         load = 1'b0;
         tick();
      end
   endtask

   initial begin
      int fend;
      int n;
      int tgt;
      bit seen;

      //            cyc  ld   val    en     dp     seg    dp sel fd
      vecs.push_back(mk(0,   0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 0, 0));
      vecs.push_back(mk(1,   0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 0, 0));
      vecs.push_back(mk(2,   0, 8'h00, 2'b11, 2'b00, 7'h3F, 0, 0, 0));
      vecs.push_back(mk(5,   1, 8'hA5, 2'b11, 2'b00, 7'h3F, 0, 0, 0));
      vecs.push_back(mk(9,   0, 8'h00, 2'b11, 2'b00, 7'h3F, 0, 0, 0));
      vecs.push_back(mk(10,  0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 1, 0));
      vecs.push_back(mk(11,  0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 1, 0));
      vecs.push_back(mk(12,  0, 8'h00, 2'b11, 2'b00, 7'h3F, 0, 1, 0));
      vecs.push_back(mk(18,  0, 8'h00, 2'b11, 2'b00, 7'h3F, 0, 1, 0));
      vecs.push_back(mk(19,  0, 8'h00, 2'b11, 2'b00, 7'h3F, 0, 1, 1));
      vecs.push_back(mk(20,  0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 0, 0));
      vecs.push_back(mk(21,  0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 0, 0));
      vecs.push_back(mk(22,  0, 8'h00, 2'b11, 2'b00, 7'h6D, 0, 0, 0));
      vecs.push_back(mk(29,  0, 8'h00, 2'b11, 2'b00, 7'h6D, 0, 0, 0));
      vecs.push_back(mk(30,  0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 1, 0));
      vecs.push_back(mk(32,  0, 8'h00, 2'b11, 2'b00, 7'h77, 0, 1, 0));
      vecs.push_back(mk(39,  0, 8'h00, 2'b11, 2'b00, 7'h77, 0, 1, 1));
      vecs.push_back(mk(43,  1, 8'h12, 2'b11, 2'b00, 7'h6D, 0, 0, 0));
      vecs.push_back(mk(45,  0, 8'h00, 2'b11, 2'b00, 7'h6D, 0, 0, 0));
      vecs.push_back(mk(55,  1, 8'h34, 2'b11, 2'b00, 7'h77, 0, 1, 0));
      vecs.push_back(mk(59,  0, 8'h00, 2'b11, 2'b00, 7'h77, 0, 1, 1));
      vecs.push_back(mk(62,  0, 8'h00, 2'b11, 2'b00, 7'h66, 0, 0, 0));
      vecs.push_back(mk(72,  0, 8'h00, 2'b11, 2'b00, 7'h4F, 0, 1, 0));
      vecs.push_back(mk(79,  1, 8'h7E, 2'b11, 2'b00, 7'h4F, 0, 1, 1));
      vecs.push_back(mk(80,  0, 8'h00, 2'b11, 2'b00, 7'h00, 0, 0, 0));
      vecs.push_back(mk(82,  0, 8'h00, 2'b11, 2'b00, 7'h79, 0, 0, 0));
      vecs.push_back(mk(89,  0, 8'h00, 2'b11, 2'b00, 7'h79, 0, 0, 0));
      vecs.push_back(mk(92,  0, 8'h00, 2'b11, 2'b00, 7'h07, 0, 1, 0));
      vecs.push_back(mk(99,  1, 8'h88, 2'b11, 2'b00, 7'h07, 0, 1, 1));
      vecs.push_back(mk(100, 0, 8'h00, 2'b01, 2'b11, 7'h00, 0, 0, 0));
      vecs.push_back(mk(102, 0, 8'h00, 2'b01, 2'b11, 7'h7F, 1, 0, 0));
      vecs.push_back(mk(109, 0, 8'h00, 2'b01, 2'b11, 7'h7F, 1, 0, 0));
      vecs.push_back(mk(110, 0, 8'h00, 2'b01, 2'b11, 7'h00, 0, 1, 0));
      vecs.push_back(mk(112, 0, 8'h00, 2'b01, 2'b11, 7'h00, 0, 1, 0));
      vecs.push_back(mk(119, 0, 8'h00, 2'b01, 2'b11, 7'h00, 0, 1, 1));
      vecs.push_back(mk(120, 0, 8'h00, 2'b01, 2'b11, 7'h00, 0, 0, 0));
      vecs.push_back(mk(122, 0, 8'h00, 2'b01, 2'b11, 7'h7F, 1, 0, 0));
      vecs.push_back(mk(125, 0, 8'h00, 2'b10, 2'b00, 7'h00, 0, 0, 0));
      vecs.push_back(mk(132, 0, 8'h00, 2'b10, 2'b00, 7'h7F, 0, 1, 0));
      vecs.push_back(mk(135, 0, 8'h00, 2'b10, 2'b10, 7'h7F, 1, 1, 0));
      vecs.push_back(mk(139, 0, 8'h00, 2'b10, 2'b10, 7'h7F, 1, 1, 1));

      rst = 1'b1; load = 1'b0; value = 8'h00; digit_en = 2'b11; dp_in = 2'b00;
      tick();
      chk_all("reset_hold", 7'h00, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("reset_hold2", 7'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cur = 0;

      foreach (vecs[i]) begin
         run_to(vecs[i].cyc);
         digit_en = vecs[i].en;
         dp_in    = vecs[i].dp;
         load     = vecs[i].ld;
         value    = vecs[i].val;
         #1;
         chk_all("vec", vecs[i].e_seg, vecs[i].e_dp, vecs[i].e_sel, vecs[i].e_fd);
         tick();
         load = 1'b0;
      end

      // Every nibble through both digits, loaded on the frame boundary.
      digit_en = 2'b11;
      dp_in    = 2'b00;
      fend     = 159;
      for (int k = 0; k < 16; k++) begin
         run_to(fend);
         load  = 1'b1;
         value = {4'(k), 4'(k)};
         tick();
         load = 1'b0;
         run_to(fend + 3);
         chk_all($sformatf("hex%0d_d0", k), hex_tbl[k], 1'b0, 1'b0, 1'b0);
         run_to(fend + 13);
         chk_all($sformatf("hex%0d_d1", k), hex_tbl[k], 1'b0, 1'b1, 1'b0);
         fend += 20;
      end

      // Frame period measured between consecutive frame_done pulses.
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         seen = frame_done;
      end
      chk("fd_first_seen", cur, {7'b0, seen}, 8'h01);
      n = 0;
      seen = 1'b0;
      while (n < 40 && !seen) begin
         tick();
         n++;
         seen = frame_done;
      end
      chk("frame_len", cur, 8'(n), 8'd20);

      // Mid-frame reset with a coincident load that must be dropped.
      tgt = cur - (cur % 20) + 34;
      run_to(tgt);
      rst   = 1'b1;
      load  = 1'b1;
      value = 8'hFF;
      #1;
      chk_all("pre_rst", 7'h71, 1'b0, 1'b1, 1'b0);
      tick();
      rst  = 1'b0;
      load = 1'b0;
      cur  = 0;
      chk_all("post_rst_c0", 7'h00, 1'b0, 1'b0, 1'b0);
      run_to(2);
      chk_all("post_rst_c2", 7'h3F, 1'b0, 1'b0, 1'b0);
      run_to(12);
      chk_all("post_rst_c12", 7'h3F, 1'b0, 1'b1, 1'b0);
      run_to(19);
      chk_all("post_rst_c19", 7'h3F, 1'b0, 1'b1, 1'b1);
      run_to(22);
      chk_all("post_rst_c22", 7'h3F, 1'b0, 1'b0, 1'b0);
      run_to(32);
      chk_all("post_rst_c32", 7'h3F, 1'b0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
